// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory master: access sizes, byte masks and FSM states.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: places store data/mask on the 64-bit bus and
// extracts/extends load data, flagging accesses that cross their natural alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_sh,
    output logic [7:0]  wmask,
    output logic [63:0] rdata_ext,
    output logic        misaligned
);

    logic [63:0] rsh;
    logic [63:0] wtrunc;

    always_comb begin
        rsh        = rdata >> {offset, 3'b000};
        wtrunc     = wdata;
        rdata_ext  = rsh;
        misaligned = 1'b0;
        // Unused upper store bytes are cleared so lanes outside the mask stay zero.
        case (size)
            SZ_B: begin
                wtrunc    = {56'd0, wdata[7:0]};
                rdata_ext = is_unsigned ? {56'd0, rsh[7:0]} : {{56{rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                wtrunc     = {48'd0, wdata[15:0]};
                rdata_ext  = is_unsigned ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
                misaligned = offset[0];
            end
            SZ_W: begin
                wtrunc     = {32'd0, wdata[31:0]};
                rdata_ext  = is_unsigned ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
                misaligned = |offset[1:0];
            end
            default: begin
                misaligned = |offset;
            end
        endcase
        wdata_sh = wtrunc << {offset, 3'b000};
        wmask    = base_mask(size) << offset;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU-side memory initiator: one outstanding access, aligned 64-bit bus with byte
// mask, ack timeout, and a registered valid/ready response channel.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    lsu_state_t  state_q, state_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wen_q, mem_wen_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_wmask_q, mem_wmask_d;

    logic [1:0]  al_size;
    logic [2:0]  al_off;
    logic        al_uns;
    logic [63:0] al_wdata_sh;
    logic [7:0]  al_wmask;
    logic [63:0] al_rdata_ext;
    logic        al_misaligned;

    // In IDLE the aligner sees the incoming request; afterwards the latched one.
    always_comb begin
        al_size = (state_q == ST_IDLE) ? req_size     : size_q;
        al_off  = (state_q == ST_IDLE) ? req_addr[2:0] : off_q;
        al_uns  = (state_q == ST_IDLE) ? req_unsigned : uns_q;
    end

    lsu_align u_align (
        .size        (al_size),
        .offset      (al_off),
        .is_unsigned (al_uns),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .wdata_sh    (al_wdata_sh),
        .wmask       (al_wmask),
        .rdata_ext   (al_rdata_ext),
        .misaligned  (al_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_en_d     = mem_en_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d       = req_wen;
                    size_d      = req_size;
                    off_d       = req_addr[2:0];
                    uns_d       = req_unsigned;
                    req_ready_d = 1'b0;
                    if (al_misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = 16'd0;
                        mem_en_d    = 1'b1;
                        mem_wen_d   = req_wen;
                        mem_addr_d  = {req_addr[63:3], 3'b000};
                        mem_wdata_d = al_wdata_sh;
                        mem_wmask_d = al_wmask;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack || cnt_q == TO_LAST) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_ack;
                    resp_rdata_d = (mem_ack && !wen_q) ? al_rdata_ext : 64'd0;
                    mem_en_d     = 1'b0;
                    mem_wen_d    = 1'b0;
                    mem_wmask_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wen_q        <= 1'b0;
            size_q       <= SZ_B;
            off_q        <= 3'd0;
            uns_q        <= 1'b0;
            cnt_q        <= 16'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
            mem_wmask_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            off_q        <= off_d;
            uns_q        <= uns_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_raddr  = mem_addr_q;
    assign mem_waddr  = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Initiator-side memory port for the NPC core. Sits between the execute/LSU stage and the 64-bit DPI-backed physical-memory responder. It accepts one byte/half/word/double load or store at a time, converts it to an 8-byte-aligned access with byte mask, waits for the memory acknowledge, and returns shifted, sign- or zero-extended load data through a valid/ready response channel.

## Interface
- TIMEOUT, 255: maximum cycles in ACCESS without `mem_ack` before an error response (1..65535).
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when `req_valid && req_ready`.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned (bits [8·n-1:0] used).
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when `resp_valid && resp_ready`.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or timeout.
- mem_en  out  1  memory access enable.
- mem_wen  out  1  write enable (valid with `mem_en`).
- mem_raddr  out  64  aligned read address, `{addr[63:3],3'b000}`.
- mem_waddr  out  64  aligned write address, same value as `mem_raddr`.
- mem_wdata  out  64  store data shifted left by `8*addr[2:0]`.
- mem_wmask  out  8  byte mask shifted left by `addr[2:0]`.
- mem_rdata  in  64  memory read data, sampled in a cycle with `mem_ack`.
- mem_ack  in  1  access completes this cycle; tie high for a zero-wait memory.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready = 1`.
  - On handshake, latch wen, addr, wdata, size, and unsigned.
  - Misaligned request: go to RESP with `err = 1`, `rdata = 0`, and no memory access. Misaligned means half with `addr[0] != 0`, word with `addr[1:0] != 0`, or double with `addr[2:0] != 0`.
  - Aligned request: go to ACCESS and clear the timeout counter.
- ACCESS:
  - `mem_en = 1` and `mem_wen = latched wen`; address, data, and mask are held stable.
  - Base mask: size 0 = `8'h01`, 1 = `8'h03`, 2 = `8'h0F`, 3 = `8'hFF`; it is shifted by offset.
  - On `mem_ack`:
    - Load: `rdata = mem_rdata >> (8*offset)`, truncated to the size, then sign- or zero-extended to 64 bits.
    - Store: `rdata = 0`.
    - In both cases `err = 0`, then go to RESP.
  - On no ack: increment the counter. When the counter reaches TIMEOUT−1 without ack, go to RESP with `err = 1`, `rdata = 0`.
- RESP:
  - `resp_valid = 1`; `resp_rdata` and `resp_err` are held until `resp_ready`, then go to IDLE.
  - `req_ready = 0` until IDLE is reached, so there is no back-to-back accept in the release cycle.
- Outside ACCESS, `mem_en = mem_wen = 0` and `mem_wmask = 0`.
- Reset value of every output: `req_ready = 1` (IDLE), and all other outputs are 0.
- Reset mid-operation: rst in any state forces IDLE at the next edge. Any pending response is dropped, and `mem_en` deasserts in that edge's cycle.

## Timing
- Request accepted at edge 0. ACCESS runs from cycle 1. With `mem_ack = 1` in cycle 1, `resp_valid` is asserted from cycle 2. Load-to-response latency is 2 cycles.
- Misaligned request: `resp_valid` from cycle 1.
- Throughput with zero-wait memory and `resp_ready = 1`: one access per 3 cycles.
- Memory outputs are registered state decodes; there is no combinational path from `req_*` to `mem_*`. `mem_rdata` is registered into `resp_rdata`.
- The counter is 16 bits wide, and comparisons use the zero-extended value of TIMEOUT.

## Structure
- Shared package `lsu_pkg`:
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - State enum `lsu_state_t` covering IDLE, ACCESS, and RESP.
  - Mask constants per size.
- Sub-module `lsu_align` is purely combinational. Its inputs are size, offset, unsigned, wdata, and rdata. Its outputs are the shifted wdata, the wmask, the extended rdata, and a misaligned flag. The top level holds the FSM, the latches, and the counter.

## Test plan
- Load byte, signed: addr `0x80000005`, size 0, `mem_rdata = 0x0000_8000_0000_0000` → `mem_raddr = 0x80000000`, `resp_rdata = 0xFFFF_FFFF_FFFF_FF80`, `resp_valid` at cycle 2.
- Store half: addr `0x80000006`, wdata `0x1234`, `mem_ack = 1` → `mem_wmask = 0xC0`, `mem_wdata = 0x1234_0000_0000_0000`, `resp_rdata = 0`, `err = 0`.
- Misaligned word load at `0x80000002` → `mem_en` never asserts, `resp_err = 1` at cycle 1.
- Timeout: TIMEOUT = 4, `mem_ack` held 0 → `mem_en` high for 4 cycles, then `resp_err = 1`.
- Backpressure: `resp_ready = 0` for 5 cycles after a word unsigned load of `0xFFFF_FFFF` → `resp_rdata = 0x0000_0000_FFFF_FFFF` stable, `req_ready = 0` throughout.
- Reset asserted while in ACCESS with `mem_ack = 0` → after the next edge `mem_en = 0`, `resp_valid = 0`, `req_ready = 1`.
